// File: rtl/sync_f2s_arb.sv
// Round-robin scheduler that issues spaced rd_en pulses into a fast-to-slow synchronizer
// and waits for the returned slow-side completion before the next grant.
module sync_f2s_arb #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int GAP_CYC = 8,
  parameter int TMO_CYC = 64,
  parameter int CNT_W   = 8
) (
  input  logic             clk_f,
  input  logic             rst_f,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             rd_en_o,
  output logic [ID_W-1:0]  rd_id_o,
  input  logic             ack_i,
  output logic             busy_o,
  output logic             tmo_o,
  input  logic             tmo_clr_i
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, GAP} state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic             rd_en_nxt, busy_nxt, tmo_nxt, tmo_set;
  logic [ID_W-1:0]  rd_id_nxt;
  logic [ID_W-1:0]  pick_hi, pick_lo, pick;
  logic             found_hi, found_lo, found;

  // Lowest set request at or above ptr wins; otherwise wrap to the lowest set below ptr.
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (req_i[j] && (ID_W'(j) >= ptr) && !found_hi) begin
        found_hi = 1'b1;
        pick_hi  = ID_W'(j);
      end
      if (req_i[j] && (ID_W'(j) < ptr) && !found_lo) begin
        found_lo = 1'b1;
        pick_lo  = ID_W'(j);
      end
    end
    found = found_hi | found_lo;
    pick  = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = '0;
    rd_en_nxt = 1'b0;
    rd_id_nxt = rd_id_o;
    busy_nxt  = busy_o;
    tmo_set   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = WAIT_ACK;
          gnt_nxt   = N_REQ'(1) << pick;
          rd_en_nxt = 1'b1;
          rd_id_nxt = pick;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
          ptr_nxt   = (pick == LAST_ID) ? '0 : pick + 1'b1;
        end
      end
      WAIT_ACK: begin
        // A late ack on the timeout cycle still counts as a normal completion.
        if (ack_i || (cnt == TMO_LAST)) begin
          tmo_set = !ack_i;
          cnt_nxt = '0;
          if (GAP_CYC == 0) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt = GAP;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
    tmo_nxt = tmo_set ? 1'b1 : (tmo_clr_i ? 1'b0 : tmo_o);
  end

  always_ff @(posedge clk_f) begin
    if (rst_f) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gnt_o   <= '0;
      rd_en_o <= 1'b0;
      rd_id_o <= '0;
      busy_o  <= 1'b0;
      tmo_o   <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      gnt_o   <= gnt_nxt;
      rd_en_o <= rd_en_nxt;
      rd_id_o <= rd_id_nxt;
      busy_o  <= busy_nxt;
      tmo_o   <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_sync_f2s_arb.sv
// Bench for sync_f2s_arb: expected grant ids are queued as requests are driven and
// compared whenever the DUT emits an rd_en pulse.
module tb_sync_f2s_arb;

  logic       clk_f;
  logic       rst_f;
  logic [3:0] req_i;
  logic [3:0] gnt_o;
  logic       rd_en_o;
  logic [1:0] rd_id_o;
  logic       ack_i;
  logic       busy_o;
  logic       tmo_o;
  logic       tmo_clr_i;

  int check_count = 0;
  int pass_count  = 0;
  int cyc         = 0;
  int model_ptr   = 0;
  int exp_q[$];
  int exp_id;

  sync_f2s_arb #(
    .N_REQ(4), .ID_W(2), .GAP_CYC(8), .TMO_CYC(64), .CNT_W(8)
  ) dut (
    .clk_f(clk_f), .rst_f(rst_f), .req_i(req_i), .gnt_o(gnt_o),
    .rd_en_o(rd_en_o), .rd_id_o(rd_id_o), .ack_i(ack_i), .busy_o(busy_o),
    .tmo_o(tmo_o), .tmo_clr_i(tmo_clr_i)
  );

  initial clk_f = 1'b0;
  always #5 clk_f = ~clk_f;

  always @(posedge clk_f) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    check_count++;
    if (got === want) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic ack, input logic clr);
    req_i     = req;
    ack_i     = ack;
    tmo_clr_i = clr;
  endtask

  task automatic tick();
    @(posedge clk_f);
    #1;
  endtask

  function automatic int pick_model(input logic [3:0] r, input int p);
    logic [1:0] j;
    for (int i = 0; i < 4; i++) begin
      j = 2'(p + i);
      if (r[j]) return int'(j);
    end
    return -1;
  endfunction

  task automatic push_grant(input logic [3:0] r);
    int k;
    k = pick_model(r, model_ptr);
    exp_q.push_back(k);
    model_ptr = (k + 1) % 4;
  endtask

  task automatic wait_pulse(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (rd_en_o === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput("pulse_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy_o !== 1'b0; i++) tick();
    if (busy_o !== 1'b0) checkOutput("idle_timeout", 0, 1);
  endtask

  task automatic reset_dut();
    rst_f = 1'b1;
    applyStimulus(4'h0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_busy_tmo", {30'd0, busy_o, tmo_o}, 0);
    rst_f = 1'b0;
    model_ptr = 0;
  endtask

  // Grant pre_req, reset during its WAIT_ACK, then confirm the pointer restarted at 0.
  task automatic reset_mid(input logic [3:0] pre_req);
    applyStimulus(pre_req, 1'b0, 1'b0);
    push_grant(pre_req);
    tick();
    checkOutput("rm_pulse", rd_en_o, 1);
    rst_f = 1'b1;
    tick();
    checkOutput("rm_outputs", {gnt_o, rd_en_o, busy_o}, 0);
    rst_f = 1'b0;
    model_ptr = 0;
    applyStimulus(4'b1001, 1'b0, 1'b0);
    push_grant(4'b1001);
    tick();
    checkOutput("rm_regrant", rd_en_o, 1);
    applyStimulus(4'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(4'h0, 1'b0, 1'b0);
    wait_idle();
  endtask

  // Scoreboard side: every pulse must match the oldest queued expectation.
  always @(negedge clk_f) begin
    if (rd_en_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_pulse", 1, 0);
      end else begin
        exp_id = exp_q.pop_front();
        checkOutput("rd_id", 32'(rd_id_o), exp_id);
        checkOutput("gnt", 32'(gnt_o), 32'(1) << exp_id);
      end
    end
  end

  initial begin
    int last;
    rst_f = 1'b1;
    applyStimulus(4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("reset_outputs", {gnt_o, rd_en_o, rd_id_o, busy_o, tmo_o}, 0);
    end
    rst_f = 1'b0;
    applyStimulus(4'hF, 1'b0, 1'b0);
    push_grant(4'hF);
    tick();
    checkOutput("first_latency", rd_en_o, 1);
    applyStimulus(4'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(4'h0, 1'b0, 1'b0);
    wait_idle();

    // Single request, ack three cycles after the pulse.
    applyStimulus(4'b0100, 1'b0, 1'b0);
    push_grant(4'b0100);
    for (int i = 1; i <= 13; i++) begin
      tick();
      applyStimulus(4'h0, (i == 4), 1'b0);
      if (i == 1) checkOutput("t2_pulse", rd_en_o, 1);
      checkOutput("t2_busy", busy_o, (i <= 12));
    end

    // All requesters held; ack one cycle after each pulse.
    reset_dut();
    applyStimulus(4'hF, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) push_grant(4'hF);
    last = 0;
    for (int n = 0; n < 5; n++) begin
      wait_pulse(20);
      if (n > 0) checkOutput("t3_spacing", cyc - last, 11);
      last = cyc;
      applyStimulus((n == 4) ? 4'h0 : 4'hF, 1'b0, 1'b0);
      tick();
      applyStimulus((n == 4) ? 4'h0 : 4'hF, 1'b1, 1'b0);
      tick();
      applyStimulus((n == 4) ? 4'h0 : 4'hF, 1'b0, 1'b0);
    end
    wait_idle();

    // Timeout, stickiness, clear, and clear colliding with a new timeout.
    applyStimulus(4'b0010, 1'b0, 1'b0);
    push_grant(4'b0010);
    tick();
    checkOutput("t4_pulse", rd_en_o, 1);
    applyStimulus(4'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 64; i++) begin
      tick();
      checkOutput("t4_tmo", tmo_o, (i >= 64));
    end
    checkOutput("t4_gap_busy", busy_o, 1);
    wait_idle();
    applyStimulus(4'b0100, 1'b0, 1'b0);
    push_grant(4'b0100);
    tick();
    checkOutput("t4_pulse2", rd_en_o, 1);
    applyStimulus(4'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(4'h0, 1'b0, 1'b0);
    wait_idle();
    checkOutput("t4_tmo_held", tmo_o, 1);
    applyStimulus(4'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(4'h0, 1'b0, 1'b0);
    checkOutput("t4_tmo_clr", tmo_o, 0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    push_grant(4'b0001);
    tick();
    checkOutput("t4_pulse3", rd_en_o, 1);
    applyStimulus(4'h0, 1'b0, 1'b0);
    repeat (63) tick();
    applyStimulus(4'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(4'h0, 1'b0, 1'b0);
    checkOutput("t4_set_wins", tmo_o, 1);
    tick();
    checkOutput("t4_set_stays", tmo_o, 1);
    wait_idle();
    applyStimulus(4'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(4'h0, 1'b0, 1'b0);
    checkOutput("t4_tmo_clr2", tmo_o, 0);

    // Ack lands exactly on the timeout cycle.
    applyStimulus(4'b1000, 1'b0, 1'b0);
    push_grant(4'b1000);
    tick();
    checkOutput("t5_pulse", rd_en_o, 1);
    applyStimulus(4'h0, 1'b0, 1'b0);
    repeat (63) tick();
    applyStimulus(4'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(4'h0, 1'b0, 1'b0);
    checkOutput("t5_tmo", tmo_o, 0);
    for (int i = 64; i <= 72; i++) begin
      if (i > 64) tick();
      checkOutput("t5_gap_busy", busy_o, (i < 72));
    end

    reset_mid(4'b1000);
    reset_mid(4'b0010);

    checkOutput("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
